// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - E-stage handshake and operand/result bundle for the RV32M multiply/divide unit
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  clrE;
    logic                  StartE;
    logic [2:0]            Funct3E;
    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic                  busyE;
    logic                  doneE;
    logic [DATA_WIDTH-1:0] ResultE;

    // Pipeline side: issues the instruction and consumes the result.
    modport master (
        output clrE, StartE, Funct3E, SrcAE, SrcBE,
        input  busyE, doneE, ResultE
    );

    // Execution unit side.
    modport slave (
        input  clrE, StartE, Funct3E, SrcAE, SrcBE,
        output busyE, doneE, ResultE
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (optional MULDIV_FAST_MUL_EN single-cycle multiply)
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [2:0]      f3;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;       // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]    opb;       // MUL: multiplicand; DIV: divisor
    logic            neg_q;     // negate product / quotient at the end
    logic            neg_r;     // negate remainder at the end (dividend sign)
    logic [W-1:0]    result_q;
    logic            done_q;

    logic            start;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;
    logic            div0, ovf;
    logic [W-1:0]    sp_res;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next, mul_fin;
    logic [W-1:0]    mul_res;
    logic [W:0]      div_shift, div_trial;
    logic [2*W-1:0]  div_next;
    logic [W-1:0]    quot, rem, div_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  fast_prod;
    logic [W-1:0]    fast_res;
`endif

    // Operand preparation, special-case detection and one iteration step of each algorithm.
    always_comb begin
        start  = (state == IDLE) && bus.StartE && !bus.clrE;
        a_sgn  = (bus.Funct3E == 3'b001) || (bus.Funct3E == 3'b010) ||
                 (bus.Funct3E == 3'b100) || (bus.Funct3E == 3'b110);
        b_sgn  = (bus.Funct3E == 3'b001) || (bus.Funct3E == 3'b100) || (bus.Funct3E == 3'b110);
        a_neg  = a_sgn && bus.SrcAE[W-1];
        b_neg  = b_sgn && bus.SrcBE[W-1];
        abs_a  = a_neg ? -bus.SrcAE : bus.SrcAE;
        abs_b  = b_neg ? -bus.SrcBE : bus.SrcBE;

        // Divide by zero and signed overflow bypass the iteration entirely.
        div0   = (bus.SrcBE == '0);
        ovf    = !bus.Funct3E[0] && (bus.SrcAE == {1'b1, {(W-1){1'b0}}}) && (bus.SrcBE == '1);
        if (div0)
            sp_res = bus.Funct3E[1] ? bus.SrcAE : '1;
        else
            sp_res = bus.Funct3E[1] ? '0 : bus.SrcAE;

        // Shift-add: conditionally add multiplicand to the high half, then shift right.
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc[W-1:1]};
        mul_fin  = neg_q ? -mul_next : mul_next;
        mul_res  = (f3 == 3'b000) ? mul_fin[W-1:0] : mul_fin[2*W-1:W];

        // Restoring divide: shift in next dividend bit, keep the trial difference if non-negative.
        div_shift = acc[2*W-1:W-1];
        div_trial = div_shift - {1'b0, opb};
        if (div_trial[W])
            div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        else
            div_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        quot    = div_next[W-1:0];
        rem     = div_next[2*W-1:W];
        div_res = f3[1] ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);

`ifdef MULDIV_FAST_MUL_EN
        // Sign-extend to full product width; the low 2W bits of the product are exact.
        fast_prod = {{W{a_neg}}, bus.SrcAE} * {{W{b_neg}}, bus.SrcBE};
        fast_res  = (bus.Funct3E == 3'b000) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif
    end

    // Stall request; dropped immediately by a flush or reset so the hazard unit releases.
    assign bus.busyE   = !rst && !bus.clrE && (start || (state == MUL) || (state == DIV));
    assign bus.doneE   = done_q;
    assign bus.ResultE = result_q;

    // Control FSM with operand latching, iteration and registered result/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            f3       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (bus.clrE) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.StartE) begin
                        f3    <= bus.Funct3E;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= CW'(W);
                        if (bus.Funct3E[2]) begin
                            if (div0 || ovf) begin
                                result_q <= sp_res;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else begin
                                acc   <= {{W{1'b0}}, abs_a};
                                opb   <= abs_b;
                                state <= DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
`else
                            acc   <= {{W{1'b0}}, abs_b};
                            opb   <= abs_a;
                            state <= MUL;
`endif
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result_q <= mul_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result_q <= div_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
